dm_wb_mux: RTL and testbench

Parametrised writeback-select stage for the data-memory path. It picks one of NUM_IN result sources and, for the memory-read source, performs byte/halfword extraction and sign/zero extension. The result is registered behind a valid/ready handshake, so the stage gives one cycle of latency and can be stalled. It sits between the data memory / ALU result buses and the register-file write port, replacing the plain 2:1 combinational writeback mux.

---
 rtl/dm_wb_mux_if.sv | 37 +++
 rtl/dm_wb_mux.sv | 113 +++++++++++
 tb/tb_dm_wb_mux.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/dm_wb_mux_if.sv
// rtl/dm_wb_mux_if.sv - request/response bundle for the writeback-select stage
//
// Purpose : groups the upstream request, downstream result and status signals
//           of dm_wb_mux so they travel as one port.
// Signals : in_valid/in_ready/in_data/sel/load_size/load_signed/byte_off
//           (request side), out_valid/out_ready/out_data/out_err (result
//           side), err_count (status).
// Modports: master - the environment driving requests and consuming results
//           slave  - the writeback-select stage itself
interface dm_wb_mux_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
);
  logic                    in_valid;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [SEL_W-1:0]        sel;
  logic [1:0]              load_size;
  logic                    load_signed;
  logic [1:0]              byte_off;
  logic                    out_valid;
  logic                    out_ready;
  logic [WIDTH-1:0]        out_data;
  logic                    out_err;
  logic [7:0]              err_count;

  modport master (
    output in_valid, in_data, sel, load_size, load_signed, byte_off, out_ready,
    input  in_ready, out_valid, out_data, out_err, err_count
  );

  modport slave (
    input  in_valid, in_data, sel, load_size, load_signed, byte_off, out_ready,
    output in_ready, out_valid, out_data, out_err, err_count
  );
endinterface

// File: rtl/dm_wb_mux.sv
// rtl/dm_wb_mux.sv - registered writeback-select stage with load alignment
//
// Purpose : selects one of NUM_IN result channels for the register-file write
//           port. Channel 0 is memory read data and gets byte/half/word lane
//           extraction with sign or zero extension. The result sits in a
//           single output register behind a valid/ready handshake.
// Ports   : clk    - rising-edge clock
//           rst    - synchronous active-high reset
//           io_bus - dm_wb_mux_if.slave (request, result, err_count)
module dm_wb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 4,
  parameter int SEL_W  = 2
) (
  input logic         clk,
  input logic         rst,
  dm_wb_mux_if.slave  io_bus
);

  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  logic             r_err;
  logic [7:0]       r_err_count;

  logic [31:0]      w_d;
  logic [7:0]       w_byte;
  logic [15:0]      w_half;
  logic [WIDTH-1:0] w_ch0;
  logic             w_ch0_err;
  logic [WIDTH-1:0] w_res;
  logic             w_err;
  logic             w_accept;

  // Channel 0 load alignment.
  always_comb begin
    w_d       = io_bus.in_data[31:0];
    w_byte    = w_d[7:0];
    w_ch0     = '0;
    w_ch0_err = 1'b0;
    case (io_bus.byte_off)
      2'd0:    w_byte = w_d[7:0];
      2'd1:    w_byte = w_d[15:8];
      2'd2:    w_byte = w_d[23:16];
      default: w_byte = w_d[31:24];
    endcase
    w_half = io_bus.byte_off[1] ? w_d[31:16] : w_d[15:0];
    case (io_bus.load_size)
      2'b00: w_ch0 = {{(WIDTH-8){io_bus.load_signed & w_byte[7]}}, w_byte};
      2'b01: begin
        if (io_bus.byte_off[0]) begin
          w_ch0_err = 1'b1;
        end else begin
          w_ch0 = {{(WIDTH-16){io_bus.load_signed & w_half[15]}}, w_half};
        end
      end
      // 11 is reserved and behaves as a word load.
      default: begin
        if (io_bus.byte_off != 2'b00) begin
          w_ch0_err = 1'b1;
        end else begin
          w_ch0 = io_bus.in_data[WIDTH-1:0];
        end
      end
    endcase
  end

  // Channel select. Out-of-range selects produce zero data with an error.
  always_comb begin
    w_res = '0;
    w_err = 1'b0;
    if (int'(io_bus.sel) >= NUM_IN) begin
      w_err = 1'b1;
    end else if (io_bus.sel == '0) begin
      w_res = w_ch0;
      w_err = w_ch0_err;
    end else begin
      for (int k = 1; k < NUM_IN; k++) begin
        if (int'(io_bus.sel) == k) begin
          w_res = io_bus.in_data[k*WIDTH +: WIDTH];
        end
      end
    end
  end

  // A full register can still take a new request when the old one retires
  // in the same cycle, so the stage runs at full throughput.
  assign io_bus.in_ready = !r_valid || io_bus.out_ready;
  assign w_accept        = io_bus.in_valid && io_bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_data      <= '0;
      r_err       <= 1'b0;
      r_err_count <= 8'd0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_data  <= w_res;
      r_err   <= w_err;
      if (w_err && (r_err_count != 8'hFF)) begin
        r_err_count <= r_err_count + 8'd1;
      end
    end else if (io_bus.out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign io_bus.out_valid = r_valid;
  assign io_bus.out_data  = r_data;
  assign io_bus.out_err   = r_err;
  assign io_bus.err_count = r_err_count;

endmodule

// File: tb/tb_dm_wb_mux.sv
// tb/tb_dm_wb_mux.sv - scoreboard bench for dm_wb_mux
module tb_dm_wb_mux;

  localparam int WIDTH  = 32;
  localparam int NUM_IN = 3;
  localparam int SEL_W  = 2;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  bit   strict_lat = 1'b0;
  int   exp_cnt = 0;
  exp_t sb[$];

  dm_wb_mux_if #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) bus ();

  dm_wb_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN), .SEL_W(SEL_W)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every retired result is compared against the scoreboard head.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_err", {31'd0, bus.out_err}, {31'd0, e.err});
        if (strict_lat) chk("latency_cycle", cyc, e.acc);
      end
    end
  end

  task automatic set_req(input logic [SEL_W-1:0] s, input logic [31:0] ch0,
                         input logic [31:0] ch1, input logic [31:0] ch2,
                         input logic [1:0] sz, input logic sg, input logic [1:0] off);
    bus.sel         = s;
    bus.in_data     = {ch2, ch1, ch0};
    bus.load_size   = sz;
    bus.load_signed = sg;
    bus.byte_off    = off;
  endtask

  // Issues the current request and waits (bounded) for its accept edge.
  task automatic send(input logic [31:0] exp_data, input logic exp_err);
    int   n;
    exp_t e;
    n = 0;
    bus.in_valid = 1'b1;
    @(negedge clk);
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk("accept_timeout", 32'd1, 32'd0);
    @(posedge clk);
    #1;
    e.data = exp_data;
    e.err  = exp_err;
    e.acc  = cyc;
    sb.push_back(e);
    if (exp_err && exp_cnt < 255) exp_cnt++;
    bus.in_valid = 1'b0;
  endtask

  localparam logic [31:0] D = 32'h80F1_7F82;

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    set_req(2'd0, 32'd0, 32'd0, 32'd0, 2'b10, 1'b0, 2'd0);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_out_data", bus.out_data, 32'd0);
    chk("rst_out_err", {31'd0, bus.out_err}, 32'd0);
    chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
    @(posedge clk);
    #1;

    // Back-to-back pass-through channels
    strict_lat = 1'b1;
    set_req(2'd1, 32'd0, 32'd200, 32'd0, 2'b00, 1'b1, 2'd3);
    send(32'd200, 1'b0);
    set_req(2'd2, 32'd0, 32'd0, 32'd888, 2'b00, 1'b1, 2'd1);
    send(32'd888, 1'b0);

    // Channel 0 alignment
    set_req(2'd0, D, 32'd0, 32'd0, 2'b00, 1'b1, 2'd1); send(32'h0000_007F, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b00, 1'b1, 2'd0); send(32'hFFFF_FF82, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b01, 1'b0, 2'd2); send(32'h0000_80F1, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b01, 1'b1, 2'd2); send(32'hFFFF_80F1, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b00, 1'b0, 2'd3); send(32'h0000_0080, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b10, 1'b1, 2'd0); send(32'h80F1_7F82, 1'b0);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b11, 1'b1, 2'd0); send(32'h80F1_7F82, 1'b0);

    // Misalignment and illegal select
    set_req(2'd0, D, 32'd0, 32'd0, 2'b01, 1'b1, 2'd1); send(32'd0, 1'b1);
    set_req(2'd0, D, 32'd0, 32'd0, 2'b10, 1'b0, 2'd2); send(32'd0, 1'b1);
    set_req(2'd3, D, 32'd5, 32'd6, 2'b00, 1'b0, 2'd0); send(32'd0, 1'b1);
    @(negedge clk);
    chk("err_count_3", {24'd0, bus.err_count}, 32'd3);
    strict_lat = 1'b0;

    // Stall: hold a result with out_ready low while a new request waits
    @(posedge clk);
    #1 bus.out_ready = 1'b0;
    set_req(2'd1, 32'd0, 32'hA5A5_0001, 32'd0, 2'b00, 1'b0, 2'd0);
    send(32'hA5A5_0001, 1'b0);
    set_req(2'd2, 32'd0, 32'd0, 32'h5A5A_0002, 2'b00, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("stall_out_data", bus.out_data, 32'hA5A5_0001);
      @(posedge clk);
      #1;
    end
    bus.out_ready = 1'b1;
    send(32'h5A5A_0002, 1'b0);
    @(negedge clk);
    chk("release_no_bubble", {31'd0, bus.out_valid}, 32'd1);
    chk("release_data", bus.out_data, 32'h5A5A_0002);
    @(posedge clk);
    #1;

    // Saturation
    set_req(2'd3, 32'd0, 32'd0, 32'd0, 2'b00, 1'b0, 2'd0);
    for (int i = 0; i < 260; i++) send(32'd0, 1'b1);
    @(negedge clk);
    chk("err_count_sat", {24'd0, bus.err_count}, exp_cnt);
    chk("err_count_255", {24'd0, bus.err_count}, 32'd255);
    @(posedge clk);
    #1;
    send(32'd0, 1'b1);
    @(negedge clk);
    chk("err_count_hold", {24'd0, bus.err_count}, 32'd255);
    @(posedge clk);
    #1;

    // Reset mid-stream with a result in flight and a request pending
    set_req(2'd1, 32'd0, 32'd77, 32'd0, 2'b00, 1'b0, 2'd0);
    send(32'd77, 1'b0);
    set_req(2'd2, 32'd0, 32'd0, 32'd99, 2'b00, 1'b0, 2'd0);
    bus.in_valid = 1'b1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_out_data", bus.out_data, 32'd0);
    chk("midrst_err_count", {24'd0, bus.err_count}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    repeat (2) @(posedge clk);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1);
  end

endmodule
